// File: rtl/lif_scheduler.sv
// Time-multiplexed leaky integrate-and-fire scheduler: one update datapath
// sweeps N_NEURONS membrane contexts per start, with optional ring coupling.
module lif_scheduler #(
  parameter int N_NEURONS  = 4,
  parameter int THRESHOLD  = 200,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRACT    = 2,
  parameter int SYN_WEIGHT = 64,
  localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*N_NEURONS-1:0] currents,
  input  logic                   coupling_en,
  input  logic [IW-1:0]          rd_sel,
  output logic [7:0]             rd_state,
  output logic [N_NEURONS-1:0]   spikes,
  output logic                   done,
  output logic                   busy
);
  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q, state_d;

  logic [IW-1:0]                  idx_q;
  logic [N_NEURONS-1:0][7:0]      cur_q;
  logic                           coupling_q;
  logic [N_NEURONS-1:0][7:0]      mem_q;
  logic [N_NEURONS-1:0][RW-1:0]   refr_q;
  logic [N_NEURONS-1:0]           shadow_q;

  logic [IW-1:0]        prev;
  logic                 last;
  logic [8:0]           eff, sum;
  logic [7:0]           eff_sat, sum_sat;
  logic                 refr_busy, fire;
  logic [N_NEURONS-1:0] spk_next;

  // Single shared update datapath, evaluated for the neuron at idx_q.
  // Coupling reads the previous sweep's spikes register, never the shadow.
  always_comb begin
    last      = (idx_q == IW'(N_NEURONS - 1));
    prev      = (idx_q == '0) ? IW'(N_NEURONS - 1) : idx_q - 1'b1;
    eff       = {1'b0, cur_q[idx_q]} +
                ((coupling_q && spikes[prev]) ? 9'(SYN_WEIGHT) : 9'd0);
    eff_sat   = eff[8] ? 8'hFF : eff[7:0];
    sum       = {1'b0, mem_q[idx_q] >> LEAK_SHIFT} + {1'b0, eff_sat};
    sum_sat   = sum[8] ? 8'hFF : sum[7:0];
    refr_busy = (refr_q[idx_q] != '0);
    fire      = !refr_busy && (int'(sum_sat) >= THRESHOLD);
    spk_next  = shadow_q;
    spk_next[idx_q] = fire;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done = (state_q == DONE);
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q      <= '0;
      cur_q      <= '0;
      coupling_q <= 1'b0;
      mem_q      <= '0;
      refr_q     <= '0;
      shadow_q   <= '0;
      spikes     <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          idx_q      <= '0;
          cur_q      <= currents;
          coupling_q <= coupling_en;
        end
        SCAN: begin
          idx_q           <= last ? '0 : idx_q + 1'b1;
          mem_q[idx_q]    <= (refr_busy || fire) ? 8'd0 : sum_sat;
          refr_q[idx_q]   <= refr_busy ? refr_q[idx_q] - 1'b1 :
                             fire      ? RW'(REFRACT) : '0;
          shadow_q[idx_q] <= fire;
          if (last) spikes <= spk_next;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_state = 8'd0;
    if (int'(rd_sel) < N_NEURONS) rd_state = mem_q[rd_sel];
  end
endmodule

// File: tb/tb_lif_scheduler.sv
// Bench for lif_scheduler: directed scenarios plus random sweeps against an
// integer-arithmetic membrane model.
module tb_lif_scheduler;
  localparam int N = 4, TH = 200, LS = 1, RF = 2, SW = 64;

  logic           clk = 1'b0, reset = 1'b1, start = 1'b0, coupling_en = 1'b0;
  logic [8*N-1:0] currents = '0;
  logic [1:0]     rd_sel = '0;
  logic [7:0]     rd_state;
  logic [N-1:0]   spikes;
  logic           done, busy;

  lif_scheduler #(.N_NEURONS(N), .THRESHOLD(TH), .LEAK_SHIFT(LS),
                  .REFRACT(RF), .SYN_WEIGHT(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .currents(currents),
    .coupling_en(coupling_en), .rd_sel(rd_sel), .rd_state(rd_state),
    .spikes(spikes), .done(done), .busy(busy));

  always #10 clk = ~clk;

  int       n_tests = 0, n_fail = 0;
  int       m_mem[N], m_refr[N];
  bit [N-1:0] m_spk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_mem[i] = 0; m_refr[i] = 0; end
    m_spk = '0;
  endtask

  // One time step from the neuron rules, using last sweep's spikes for coupling.
  task automatic model_sweep(input int c[N], input bit cpl);
    bit [N-1:0] nxt = '0;
    for (int k = 0; k < N; k++) begin
      if (m_refr[k] != 0) begin
        m_mem[k] = 0; m_refr[k]--;
      end else begin
        int e, s;
        e = c[k] + ((cpl && m_spk[(k + N - 1) % N]) ? SW : 0);
        if (e > 255) e = 255;
        s = m_mem[k] / (1 << LS) + e;
        if (s > 255) s = 255;
        if (s >= TH) begin nxt[k] = 1'b1; m_mem[k] = 0; m_refr[k] = RF; end
        else m_mem[k] = s;
      end
    end
    m_spk = nxt;
  endtask

  function automatic logic [8*N-1:0] pack(input int c[N]);
    logic [8*N-1:0] p;
    for (int i = 0; i < N; i++) p[8*i +: 8] = 8'(c[i]);
    return p;
  endfunction

  task automatic rd(input int i, output int v);
    rd_sel = 2'(i); #1; v = int'(rd_state);
  endtask

  task automatic check_all(input string tag);
    int v;
    chk({tag, "_spikes"}, 32'(spikes), 32'(m_spk));
    for (int i = 0; i < N; i++) begin
      rd(i, v);
      chk($sformatf("%s_mem%0d", tag, i), v, m_mem[i]);
    end
  endtask

  // Launch a sweep, scramble inputs while scanning, then check against the model.
  task automatic run_sweep(input int c[N], input bit cpl, input string tag);
    int lat;
    @(negedge clk);
    currents = pack(c); coupling_en = cpl; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1;
    while (!done && lat < 30) begin
      currents = {$urandom, $urandom};
      coupling_en = 1'($urandom);
      @(negedge clk); lat++;
    end
    chk({tag, "_latency"}, lat, N + 1);
    model_sweep(c, cpl);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    int v;
    @(negedge clk); reset = 1'b1; #1;
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_spikes"}, 32'(spikes), 0);
    for (int i = 0; i < N; i++) begin
      rd(i, v); chk($sformatf("%s_rd%0d", tag, i), v, 0);
    end
    @(negedge clk); reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int c[N];
    int v;
    int exp0[10] = '{101, 151, 176, 189, 195, 198, 0, 0, 0, 101};
    logic [N-1:0] old_spk;

    model_reset();
    do_reset("por");

    // Leaky integration to threshold, then refractory period.
    c = '{101, 0, 0, 0};
    for (int s = 0; s < 10; s++) begin
      run_sweep(c, 1'b0, $sformatf("int101_s%0d", s + 1));
      rd(0, v); chk($sformatf("int101_mem0_s%0d", s + 1), v, exp0[s]);
      chk($sformatf("int101_spk0_s%0d", s + 1), 32'(spikes[0]), (s == 6) ? 1 : 0);
    end

    // Threshold boundary: settles one below and never fires.
    do_reset("rst2");
    c = '{100, 0, 0, 0};
    for (int s = 0; s < 20; s++) begin
      run_sweep(c, 1'b0, $sformatf("int100_s%0d", s + 1));
      chk($sformatf("int100_spk0_s%0d", s + 1), 32'(spikes[0]), 0);
    end
    rd(0, v); chk("int100_settle", v, 199);

    // Ring coupling from neuron 0 into neuron 1.
    do_reset("rst3");
    c = '{255, 0, 0, 0};
    run_sweep(c, 1'b1, "cpl_s1");
    chk("cpl_s1_vec", 32'(spikes), 32'b0001);
    run_sweep(c, 1'b1, "cpl_s2");
    rd(1, v); chk("cpl_s2_mem1", v, 64);
    chk("cpl_s2_spk0", 32'(spikes[0]), 0);
    run_sweep(c, 1'b1, "cpl_s3");
    rd(1, v); chk("cpl_s3_mem1", v, 32);

    // Saturating effective current: 255 + coupling must not wrap.
    do_reset("rst4");
    c = '{0, 0, 255, 0};
    run_sweep(c, 1'b1, "sat_s1");
    c = '{0, 0, 0, 255};
    run_sweep(c, 1'b1, "sat_s2");
    chk("sat_spk3", 32'(spikes[3]), 1);

    // Cycle-level timing with a second start inside the sweep.
    do_reset("rst5");
    c = '{0, 0, 0, 255};
    old_spk = spikes;
    model_sweep(c, 1'b0);
    @(negedge clk);
    currents = pack(c); coupling_en = 1'b0; start = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      start = (cyc == 2);
      chk($sformatf("tim_busy_c%0d", cyc), 32'(busy), (cyc <= 5) ? 1 : 0);
      chk($sformatf("tim_done_c%0d", cyc), 32'(done), (cyc == 5) ? 1 : 0);
      chk($sformatf("tim_spk_c%0d", cyc), 32'(spikes),
          32'((cyc >= 5) ? m_spk : old_spk));
    end
    start = 1'b0;
    check_all("tim_end");

    // Reset in the middle of a sweep, then a clean sweep from neuron 0.
    c = '{150, 90, 30, 180};
    run_sweep(c, 1'b1, "pre_mid");
    run_sweep(c, 1'b1, "pre_mid2");
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    do_reset("mid_scan");
    c = '{120, 255, 7, 201};
    run_sweep(c, 1'b1, "post_mid");

    // Random sweeps.
    for (int s = 0; s < 40; s++) begin
      for (int i = 0; i < N; i++)
        c[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
      run_sweep(c, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", s));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
